// File: rtl/feature_rd_pkg.sv
// feature_rd_pkg: shared defaults, FSM state type and clog2 helper for the feature BRAM reader.
package feature_rd_pkg;
    localparam int DEF_BRAM_DATA_WIDTH = 32;
    localparam int DEF_ADDRESS_WIDTH = 13;
    localparam int DEF_PIX_WIDTH = 16;
    localparam int DEF_BRAM_LATENCY = 2;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int PIX_PER_WORD = DEF_BRAM_DATA_WIDTH / DEF_PIX_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/feature_bram_reader_if.sv
// feature_bram_reader_if: pass control, BRAM read port and pixel stream of the feature reader.
interface feature_bram_reader_if #(
    parameter int AW = 13,
    parameter int DW = 32,
    parameter int PW = 16
);
    logic i_start;
    logic [AW-1:0] i_base_addr;
    logic [15:0] i_num_pix;
    logic o_busy;
    logic o_done;
    logic bram_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout;
    logic feature_reader_en;
    logic feature_reader_valid;
    logic [PW-1:0] feature_reader_data_out;

    modport master (
        output i_start, i_base_addr, i_num_pix, bram_dout, feature_reader_en,
        input o_busy, o_done, bram_en, bram_addr, feature_reader_valid, feature_reader_data_out
    );
    modport slave (
        input i_start, i_base_addr, i_num_pix, bram_dout, feature_reader_en,
        output o_busy, o_done, bram_en, bram_addr, feature_reader_valid, feature_reader_data_out
    );
endinterface

// File: rtl/feature_pix_fifo.sv
// feature_pix_fifo: single-clock pixel FIFO with occupancy count and synchronous flush.
module feature_pix_fifo
    import feature_rd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic wr_en,
    input  logic rd_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic empty,
    output logic [clog2(DEPTH):0] count
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;

    assign rd_data = mem[rp];
    assign empty = count == '0;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp <= wp + AW'(1);
            end
            if (rd_en) rp <= rp + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
endmodule

// File: rtl/feature_bram_reader.sv
// feature_bram_reader: fetches packed feature words from BRAM and streams them out
// one pixel per consumer request, exactly i_num_pix pixels per pass.
module feature_bram_reader
    import feature_rd_pkg::*;
#(
    parameter int BRAM_DATA_WIDTH = DEF_BRAM_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int PIX_WIDTH = DEF_PIX_WIDTH,
    parameter int BRAM_LATENCY = DEF_BRAM_LATENCY,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input logic i_clk,
    input logic i_rst_n,
    feature_bram_reader_if.slave bus
);
    localparam int PPW = BRAM_DATA_WIDTH / PIX_WIDTH;
    localparam int CW = clog2(FIFO_DEPTH);
    localparam int SW = clog2(PPW + 1);
    localparam int GW = clog2(PPW) + 1;

    state_t state;
    logic [ADDRESS_WIDTH-1:0] next_addr;
    logic [15:0] num_pix, pix_sent, words_total, words_issued, words_ret, rem;
    logic [CW+1:0] inflight;
    logic [GW-1:0] gap;
    logic [BRAM_DATA_WIDTH-1:0] ser_word;
    logic [SW-1:0] ser_left, take;
    logic [BRAM_LATENCY-1:0] lat_sr;
    logic [CW:0] fifo_count;
    logic [PIX_WIDTH-1:0] fifo_rdata;
    logic fifo_empty, pop, issue, wr, ret;

    // Issues are spaced PPW cycles apart so each returned word is fully serialized
    // before the next one lands; inflight counts words until their last pixel is written.
    assign ret = lat_sr[BRAM_LATENCY-1];
    assign wr = ser_left != '0;
    assign rem = num_pix - words_ret * 16'(PPW);
    assign take = rem > 16'(PPW) ? SW'(PPW) : SW'(rem);
    assign pop = bus.feature_reader_en && !fifo_empty && pix_sent < num_pix
                 && (state == FETCH || state == DRAIN);
    assign issue = state == FETCH && gap == '0
                   && 16'(fifo_count) + 16'(PPW) * (16'(inflight) + 16'd1) <= 16'(FIFO_DEPTH);

    feature_pix_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PIX_WIDTH)) u_fifo (
        .clk(i_clk),
        .rst_n(i_rst_n),
        .flush(state == DONE),
        .wr_en(wr),
        .rd_en(pop),
        .wr_data(ser_word[PIX_WIDTH-1:0]),
        .rd_data(fifo_rdata),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            bus.o_busy <= 1'b0;
            bus.o_done <= 1'b0;
            bus.bram_en <= 1'b0;
            bus.bram_addr <= '0;
            bus.feature_reader_valid <= 1'b0;
            bus.feature_reader_data_out <= '0;
            next_addr <= '0;
            num_pix <= '0;
            pix_sent <= '0;
            words_total <= '0;
            words_issued <= '0;
            words_ret <= '0;
            inflight <= '0;
            gap <= '0;
            ser_word <= '0;
            ser_left <= '0;
            lat_sr <= '0;
        end else begin
            lat_sr <= BRAM_LATENCY'({lat_sr, bus.bram_en});
            bus.bram_en <= issue;
            bus.o_done <= 1'b0;
            bus.feature_reader_valid <= pop;
            inflight <= inflight + (CW+2)'(issue) - (CW+2)'(wr && ser_left == SW'(1));
            if (pop) begin
                bus.feature_reader_data_out <= fifo_rdata;
                pix_sent <= pix_sent + 16'd1;
            end
            if (issue) begin
                bus.bram_addr <= next_addr;
                next_addr <= next_addr + ADDRESS_WIDTH'(1);
                words_issued <= words_issued + 16'd1;
                gap <= GW'(PPW - 1);
            end else if (gap != '0) begin
                gap <= gap - GW'(1);
            end
            // Unpack least-significant slice first; a short final word keeps only `take` slices.
            if (ret) begin
                ser_word <= bus.bram_dout;
                ser_left <= take;
                words_ret <= words_ret + 16'd1;
            end else if (wr) begin
                ser_word <= ser_word >> PIX_WIDTH;
                ser_left <= ser_left - SW'(1);
            end
            case (state)
                IDLE: if (bus.i_start) begin
                    num_pix <= bus.i_num_pix;
                    words_total <= 16'((17'(bus.i_num_pix) + 17'(PPW - 1)) / 17'(PPW));
                    next_addr <= bus.i_base_addr;
                    pix_sent <= '0;
                    words_issued <= '0;
                    words_ret <= '0;
                    bus.o_busy <= 1'b1;
                    bus.o_done <= bus.i_num_pix == '0;
                    state <= bus.i_num_pix == '0 ? DONE : FETCH;
                end
                FETCH: if (issue && words_issued + 16'd1 == words_total) state <= DRAIN;
                DRAIN: if (pop && pix_sent + 16'd1 == num_pix) begin
                    bus.o_done <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    bus.o_busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_feature_bram_reader.sv
// tb_feature_bram_reader: directed passes against a latency-2 BRAM model; a scoreboard
// queue holds expected pixels and a negedge monitor pops and compares each valid pixel.
module tb_feature_bram_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int cur_n = 0;
    logic en_q = 1'b0;
    logic [3:0] max_cnt = '0;
    logic [15:0] exp_q[$];
    logic [12:0] rd_q[$];
    logic [31:0] pipe0 = '0, pipe1 = '0;

    feature_bram_reader_if #(.AW(13), .DW(32), .PW(16)) bus ();

    feature_bram_reader dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pix(input logic [12:0] base, input int i);
        logic [12:0] a;
        a = base + 13'(i / 2);
        return {2'b0, a, 1'(i % 2)};
    endfunction

    function automatic logic [31:0] word_at(input logic [12:0] a);
        return {2'b0, a, 1'b1, 2'b0, a, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    always @(posedge clk) begin
        pipe0 <= bus.bram_en ? word_at(bus.bram_addr) : 32'hDEAD_BEEF;
        pipe1 <= pipe0;
        en_q <= bus.feature_reader_en;
    end
    assign bus.bram_dout = pipe1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bram_en) rd_q.push_back(bus.bram_addr);
            if (dut.u_fifo.count > max_cnt) max_cnt = dut.u_fifo.count;
            if (bus.feature_reader_valid) begin
                chk("valid_after_en", 32'(en_q), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_pixel: got %0h expected none", bus.feature_reader_data_out);
                end else begin
                    chk("pixel", 32'(bus.feature_reader_data_out), 32'(exp_q.pop_front()));
                end
            end
            if (bus.o_done) begin
                done_cnt++;
                if (cur_n != 0)
                    chk("done_with_last", 32'(bus.feature_reader_valid && exp_q.size() == 0), 32'd1);
            end
        end
    end

    // mode 0: en always high; 1: en pattern 1,0,0; 2: en low for 5 cycles after 14 pixels
    task automatic run(input logic [12:0] base, input int n, input int mode);
        int cyc = 0, seen = 0, hold = 0;
        bit got_done = 0;
        int words = (n + 1) / 2;
        rd_q.delete();
        done_cnt = 0;
        cur_n = n;
        for (int i = 0; i < n; i++) exp_q.push_back(pix(base, i));
        @(negedge clk);
        bus.i_base_addr = base;
        bus.i_num_pix = 16'(n);
        bus.i_start = 1'b1;
        bus.feature_reader_en = mode != 1;
        @(negedge clk);
        bus.i_start = 1'b0;
        while (!got_done && cyc < 400) begin
            if (bus.feature_reader_valid) seen++;
            if (bus.o_done) got_done = 1;
            if (mode == 1) bus.feature_reader_en = (cyc % 3) == 2;
            else if (mode == 2 && seen >= 14 && hold < 5) begin
                bus.feature_reader_en = 1'b0;
                hold++;
            end else bus.feature_reader_en = 1'b1;
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        chk("done_seen", 32'(got_done), 32'd1);
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("all_pixels_out", 32'(exp_q.size()), 32'd0);
        chk("busy_after", 32'(bus.o_busy), 32'd0);
        chk("n_reads", 32'(rd_q.size()), 32'(words));
        for (int k = 0; k < words && k < rd_q.size(); k++)
            chk("read_addr", 32'(rd_q[k]), 32'(13'(base + 13'(k))));
        exp_q.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.o_done), 32'd0);
        chk({tag, "_bram_en"}, 32'(bus.bram_en), 32'd0);
        chk({tag, "_bram_addr"}, 32'(bus.bram_addr), 32'd0);
        chk({tag, "_valid"}, 32'(bus.feature_reader_valid), 32'd0);
        chk({tag, "_data"}, 32'(bus.feature_reader_data_out), 32'd0);
    endtask

    initial begin
        int seen = 0, cyc = 0;
        bus.i_start = 1'b0;
        bus.i_base_addr = '0;
        bus.i_num_pix = '0;
        bus.feature_reader_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        run(13'h010, 16, 0);
        run(13'h020, 5, 0);
        max_cnt = '0;
        run(13'h030, 16, 1);
        chk("fifo_max_le_depth", 32'(max_cnt <= 4'd8), 32'd1);
        run(13'h050, 16, 2);
        run(13'h1FFF, 4, 0);
        run(13'h100, 0, 0);

        cur_n = 16;
        for (int i = 0; i < 16; i++) exp_q.push_back(pix(13'h100, i));
        @(negedge clk);
        bus.i_base_addr = 13'h100;
        bus.i_num_pix = 16'd16;
        bus.i_start = 1'b1;
        bus.feature_reader_en = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        while (seen < 6 && cyc < 200) begin
            @(negedge clk);
            if (bus.feature_reader_valid) seen++;
            cyc++;
        end
        chk("midreset_reached", 32'(seen), 32'd6);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_outputs_zero("midreset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(13'h040, 8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
